instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch-side consumer of the PC controller output.
- Takes the current pc_value, issues one instruction-memory read at a time over a valid/ready request channel, and captures the response into a small first-word-fall-through buffer of {pc, instruction} pairs.
- Presents buffered instructions to decode over a valid/ready channel.
- Drives pc_en back to the PC controller to advance the PC after each successful fetch; flushes on redirect (branch/JAL/JALR).

Parameters:
- DWIDTH, 32: address and instruction width.
- DEPTH, 2: instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- pc_value  input  DWIDTH  current PC from the PC controller.
- pc_en  output  1  combinational; high for exactly the cycle a non-flushed response is accepted.
- flush  input  1  redirect; discards buffered and in-flight fetches.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  DWIDTH  request address; stable while imem_req_valid is high.
- imem_rsp_valid  input  1  response valid, one cycle pulse per accepted request.
- imem_rsp_data  input  DWIDTH  fetched instruction.
- instr_valid  output  1  buffer non-empty.
- instr_ready  input  1  decode consumes the head entry.
- instr_data  output  DWIDTH  head instruction.
- instr_pc  output  DWIDTH  PC of the head instruction.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, buffer count=0, pointers=0, address register=0.
  - imem_req_valid=0, pc_en=0, instr_valid=0, instr_data=0, instr_pc=0.
- FSM states: IDLE, REQ, WAIT, DRAIN. At most one request outstanding.
- IDLE:
  - if count<DEPTH and !flush, latch addr<=pc_value and go to REQ.
  - otherwise stay in IDLE (stall when full).
- REQ:
  - imem_req_valid=1, imem_addr=latched addr.
  - on imem_req_ready, go to WAIT.
  - valid is never dropped without ready, except on flush.
- WAIT:
  - on imem_rsp_valid, push {addr, imem_rsp_data}, assert pc_en the same cycle, go to IDLE.
  - The PC controller updates at that edge, so IDLE samples the new pc_value on the next cycle.
- Latency with zero-wait memory: IDLE→REQ→WAIT→instr_valid high 3 cycles after leaving reset. Sustained throughput is 1 instruction per 3 cycles.
- Buffer: entry is reserved on leaving IDLE, so a push never overflows.
  - pop when instr_valid && instr_ready.
  - simultaneous push and pop leaves count unchanged.
  - pointers wrap modulo DEPTH.
- Flush (takes priority over everything; buffer cleared at that edge, pc_en forced 0):
  - IDLE: stay in IDLE.
  - REQ && !imem_req_ready: go to IDLE (request withdrawn).
  - REQ && imem_req_ready: go to DRAIN.
  - WAIT && imem_rsp_valid: response discarded, go to IDLE.
  - WAIT && !imem_rsp_valid: go to DRAIN.
  - DRAIN: no requests; on imem_rsp_valid, discard and go to IDLE. flush in DRAIN keeps DRAIN.
- Flush with instr_ready in the same cycle: flush wins; count=0 afterwards.
- Reset asserted mid-transaction: immediate return to reset values. The memory is reset by the same signal, so no drain is needed.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - adds output fetch_misalign (1 bit, reset 0) and state TRAP.
  - In IDLE, if pc_value[1:0]!=0 and no flush, go to TRAP instead of REQ; no request is issued.
  - TRAP holds fetch_misalign=1 and pc_en=0 until flush, then clears and goes to IDLE.
  - Buffered entries still drain to decode while in TRAP.
- Undefined: no port, no TRAP state; address bits [1:0] are passed to memory unchanged.

Test Plan:
- Reset release, pc_value=0x0000_0000, ready=1, 1-cycle response 0x0000_0013 -> imem_addr=0x0 in REQ; pc_en pulses once; instr_valid high with instr_pc=0x0, instr_data=0x13.
- instr_ready=0, pc_value stepping 0x0,0x4,0x8 -> exactly DEPTH=2 entries (0x0,0x4) buffered; no request issued for 0x8 until one pop; head order preserved.
- imem_req_ready held 0 for 5 cycles at addr 0x10 -> imem_req_valid and imem_addr=0x10 stable all 5 cycles; no pc_en.
- flush in WAIT before response, pc_value redirected to 0x40 -> DRAIN; late response discarded (no push, no pc_en); next request address 0x40.
- flush in the same cycle as imem_rsp_valid with 1 entry buffered and instr_ready=1 -> count=0, pc_en=0, state IDLE next cycle.
- IFU_MISALIGN_TRAP_EN defined, pc_value=0x0000_0102 -> no imem_req_valid, fetch_misalign=1 until flush, then 0 and a fetch of the new pc_value.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response
// channel and the buffered instruction channel toward decode.
interface instr_fetch_unit_if #(
  parameter int DWIDTH = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [DWIDTH-1:0] imem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DWIDTH-1:0] instr_data;
  logic [DWIDTH-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch with a small FWFT buffer.
// IFU_MISALIGN_TRAP_EN adds fetch_misalign and a TRAP state.
module instr_fetch_unit #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] pc_value,
  output logic              pc_en,
  input  logic              flush,
  instr_fetch_unit_if.master bus
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic              fetch_misalign
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DRAIN, TRAP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DRAIN
  } state_t;
`endif

  state_t state_q, state_d;

  logic [DWIDTH-1:0] addr_q;
  logic              load;
  logic              push;
  logic              pop;
  logic              full;

  logic [DWIDTH-1:0] data_mem [DEPTH];
  logic [DWIDTH-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign full = (count == CW'(DEPTH));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && !full) begin
`ifdef IFU_MISALIGN_TRAP_EN
          if (pc_value[1:0] != 2'b00) begin
            state_d = TRAP;
          end else begin
            state_d = REQ;
            load    = 1'b1;
          end
`else
          state_d = REQ;
          load    = 1'b1;
`endif
        end
      end
      REQ: begin
        if (flush) begin
          state_d = bus.imem_req_ready ? DRAIN : IDLE;
        end else if (bus.imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // a response arriving with flush is simply dropped
        if (bus.imem_rsp_valid) begin
          state_d = IDLE;
          push    = !flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.imem_rsp_valid) state_d = IDLE;
      end
`ifdef IFU_MISALIGN_TRAP_EN
      TRAP: begin
        if (flush) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) addr_q <= pc_value;
    end
  end

  assign pop = bus.instr_valid && bus.instr_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.imem_rsp_data;
      pc_mem[wr_ptr]   <= addr_q;
    end
  end

  assign pc_en              = push;
  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_addr      = addr_q;
  assign bus.instr_valid    = (count != '0);
  assign bus.instr_data     = bus.instr_valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_pc       = bus.instr_valid ? pc_mem[rd_ptr] : '0;

`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_misalign = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps, then random traffic
// checked against an in-order PC-stream and memory-content model.
module tb_instr_fetch_unit;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          pc_en;
  logic [DW-1:0] pc_value = '0;
`ifdef IFU_MISALIGN_TRAP_EN
  logic          fetch_misalign;
`endif

  instr_fetch_unit_if #(.DWIDTH(DW)) bus ();

  instr_fetch_unit #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_value (pc_value),
    .pc_en    (pc_en),
    .flush    (flush),
    .bus      (bus)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int lat   = 0;
  int m_cnt = 0;

  logic [31:0] exp_pc   = '0;
  logic        d_ready  = 1'b0;
  logic        d_iready = 1'b0;
  logic        d_flush  = 1'b0;
  logic [31:0] d_target = '0;

  logic        s_fire   = 1'b0;
  logic        s_pe     = 1'b0;
  logic        s_flush  = 1'b0;
  logic        s_hold   = 1'b0;
  logic [31:0] s_addr   = '0;
  logic [31:0] s_target = '0;

  logic        m_pend = 1'b0;
  logic [31:0] m_addr = '0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a << 5) | 32'h13;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Environment: PC controller and memory react to the last edge.
  task automatic update();
    if (s_flush) begin
      pc_value = s_target;
      exp_pc   = s_target;
    end else if (s_pe) begin
      pc_value = pc_value + 32'd4;
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (s_fire) begin
      m_pend = 1'b1;
      m_cnt  = lat;
      m_addr = s_addr;
    end
    if (m_pend) begin
      if (m_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = memfn(m_addr);
        m_pend = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    bus.imem_req_ready = d_ready;
    bus.instr_ready    = d_iready;
    flush              = d_flush;
  endtask

  task automatic sample();
    if (s_hold) begin
      chk1("req_hold_valid", bus.imem_req_valid, 1'b1);
      chk32("req_hold_addr", bus.imem_addr, s_addr);
    end
    if (flush) chk1("pc_en_on_flush", pc_en, 1'b0);
    s_fire   = bus.imem_req_valid && bus.imem_req_ready;
    s_pe     = pc_en;
    s_flush  = flush;
    s_target = d_target;
    s_addr   = bus.imem_addr;
    if (s_fire) chk32("req_addr", bus.imem_addr, pc_value);
    if (bus.instr_valid && bus.instr_ready && !flush) begin
      chk32("pop_pc", bus.instr_pc, exp_pc);
      chk32("pop_data", bus.instr_data, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    s_hold = bus.imem_req_valid && !bus.imem_req_ready && !flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    update();
    @(negedge clk);
    sample();
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;

    @(negedge clk);
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_instr_valid", bus.instr_valid, 1'b0);
    chk32("rst_instr_data", bus.instr_data, 32'h0);
    chk32("rst_instr_pc", bus.instr_pc, 32'h0);
    chk32("rst_addr", bus.imem_addr, 32'h0);

    // first fetch from 0x0, zero-wait memory
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    update();
    @(negedge clk);
    sample();
    chk1("idle_no_req", bus.imem_req_valid, 1'b0);
    tick();
    chk1("first_req_valid", bus.imem_req_valid, 1'b1);
    chk32("first_req_addr", bus.imem_addr, 32'h0);
    tick();
    chk1("first_pc_en", pc_en, 1'b1);
    tick();
    chk1("first_instr_valid", bus.instr_valid, 1'b1);
    chk32("first_instr_pc", bus.instr_pc, 32'h0);
    chk32("first_instr_data", bus.instr_data, 32'h13);

    // fill the buffer with decode stalled
    repeat (5) tick();
    chk1("full_no_req", bus.imem_req_valid, 1'b0);
    chk1("full_valid", bus.instr_valid, 1'b1);
    chk32("full_head", bus.instr_pc, 32'h0);
    d_iready = 1'b1;
    tick();
    d_iready = 1'b0;
    tick();
    chk32("head_after_pop", bus.instr_pc, 32'h4);
    chk1("idle_sees_full", bus.imem_req_valid, 1'b0);
    tick();
    chk1("req_after_pop", bus.imem_req_valid, 1'b1);
    chk32("req_addr_8", bus.imem_addr, 32'h8);

    // flush with a response in hand, redirect to 0x10
    d_flush  = 1'b1;
    d_target = 32'h10;
    d_ready  = 1'b0;
    tick();
    chk1("rsp_flush_pc_en", pc_en, 1'b0);
    d_flush = 1'b0;
    tick();
    chk1("flush_empties", bus.instr_valid, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("stall_valid", bus.imem_req_valid, 1'b1);
      chk32("stall_addr", bus.imem_addr, 32'h10);
      chk1("stall_pc_en", pc_en, 1'b0);
      tick();
    end

    // flush in WAIT before the response, redirect to 0x40
    d_ready = 1'b1;
    lat     = 2;
    tick();
    d_ready = 1'b0;
    tick();
    chk1("wait_no_pc_en", pc_en, 1'b0);
    d_flush  = 1'b1;
    d_target = 32'h40;
    tick();
    d_flush = 1'b0;
    tick();
    chk1("drain_rsp_seen", bus.imem_rsp_valid, 1'b1);
    chk1("drain_pc_en", pc_en, 1'b0);
    chk1("drain_no_req", bus.imem_req_valid, 1'b0);
    lat     = 0;
    d_ready = 1'b1;
    tick();
    chk1("drain_discard", bus.instr_valid, 1'b0);
    tick();
    chk1("redirect_req", bus.imem_req_valid, 1'b1);
    chk32("redirect_addr", bus.imem_addr, 32'h40);

    // flush together with a response and a pop
    tick();
    chk1("fetch40_pc_en", pc_en, 1'b1);
    tick();
    chk32("one_entry_pc", bus.instr_pc, 32'h40);
    tick();
    d_flush  = 1'b1;
    d_iready = 1'b1;
    d_target = 32'h80;
    tick();
    chk1("flush_rsp_pc_en", pc_en, 1'b0);
    d_flush  = 1'b0;
    d_iready = 1'b0;
    tick();
    chk1("flush_pop_empty", bus.instr_valid, 1'b0);
    chk1("flush_to_idle", bus.imem_req_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d_ready  = ($urandom % 10) < 7;
      d_iready = ($urandom % 10) < 6;
      d_flush  = ($urandom % 32) == 0;
      d_target = ($urandom % 256) << 2;
      lat      = int'($urandom % 3);
      tick();
    end
    d_flush  = 1'b0;
    d_ready  = 1'b1;
    d_iready = 1'b1;
    lat      = 0;
    repeat (20) tick();
    chk1("progress", pops > 100, 1'b1);

`ifdef IFU_MISALIGN_TRAP_EN
    d_flush  = 1'b1;
    d_target = 32'h102;
    tick();
    d_flush = 1'b0;
    repeat (6) tick();
    chk1("trap_flag", fetch_misalign, 1'b1);
    chk1("trap_no_req", bus.imem_req_valid, 1'b0);
    chk1("trap_pc_en", pc_en, 1'b0);
    d_flush  = 1'b1;
    d_target = 32'h200;
    tick();
    d_flush = 1'b0;
    tick();
    chk1("trap_cleared", fetch_misalign, 1'b0);
    tick();
    chk1("post_trap_req", bus.imem_req_valid, 1'b1);
    chk32("post_trap_addr", bus.imem_addr, 32'h200);
`endif

    // asynchronous reset mid-transaction
    tick();
    reset = 1'b0;
    #1;
    chk1("async_rst_req", bus.imem_req_valid, 1'b0);
    chk1("async_rst_valid", bus.instr_valid, 1'b0);
    chk1("async_rst_pc_en", pc_en, 1'b0);
    chk32("async_rst_addr", bus.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
